aspiradora_mode_sequencer: RTL and testbench



---
 rtl/aspiradora_mode_sequencer_pkg.sv | 44 ++++
 rtl/aspiradora_mode_sequencer_seq_timer.sv | 38 +++
 rtl/aspiradora_mode_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_aspiradora_mode_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aspiradora_mode_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// aspiradora_seq_pkg
// Shared types and constants for the aspiradora mode sequencer.
//   seq_state_t : sequencer state; the encoding is visible on the seq_state port.
//   DEF_*       : default parameter values for the sequencer top.
//   CMD_*       : bit positions in the one-hot command vector
//                 {evading, cleaning, on, power_off}.
//   cmd_decode  : maps a state onto its one-hot command vector.
// -----------------------------------------------------------------------------
package aspiradora_seq_pkg;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_ON     = 3'd1,
    S_CLEAN  = 3'd2,
    S_EVADE  = 3'd3,
    S_LOWBAT = 3'd4
  } seq_state_t;

  localparam int DEF_CLEAN_CYCLES = 1000;
  localparam int DEF_EVADE_CYCLES = 50;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_MAX_BUMPS    = 4;

  // One-hot command vector layout {evading, cleaning, on, power_off}
  localparam int CMD_W         = 4;
  localparam int CMD_POWER_OFF = 0;
  localparam int CMD_ON        = 1;
  localparam int CMD_CLEANING  = 2;
  localparam int CMD_EVADING   = 3;

  function automatic logic [CMD_W-1:0] cmd_decode(input seq_state_t s);
    logic [CMD_W-1:0] v;
    v = '0;
    case (s)
      S_ON:    v[CMD_ON]        = 1'b1;
      S_CLEAN: v[CMD_CLEANING]  = 1'b1;
      S_EVADE: v[CMD_EVADING]   = 1'b1;
      default: v[CMD_POWER_OFF] = 1'b1;  // OFF, LOWBAT and any illegal code
    endcase
    return v;
  endfunction

endpackage

// File: rtl/aspiradora_mode_sequencer_seq_timer.sv
// -----------------------------------------------------------------------------
// seq_timer
// Loadable, freezable, saturating up-counter with a terminal-count compare.
//   clk      : system clock
//   rst      : synchronous active-high reset, clears the count
//   i_load   : restart the count from zero (wins over i_en)
//   i_en     : count one cycle; when low the value is frozen
//   o_tc     : count has reached (or passed) TC_VALUE
// The compare is ">=" so that a count pushed past the terminal value (for
// example a clean timer that ticked on its last cycle while leaving for an
// evade) still reports expiry as soon as it is resumed.
// -----------------------------------------------------------------------------
module seq_timer #(
  parameter int               CNT_W    = 16,
  parameter logic [CNT_W-1:0] TC_VALUE = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tc = (r_count >= TC_VALUE);

endmodule

// File: rtl/aspiradora_mode_sequencer.sv
// -----------------------------------------------------------------------------
// aspiradora_mode_sequencer
// Timed command sequencer in front of the vacuum Moore FSM. Turns buttons,
// bumper and battery sensor levels into exactly one registered command line
// per cycle, with a clean-session timeout, a fixed-length evade manoeuvre and
// a low-battery shutdown.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start_btn      : request to begin/resume cleaning (level)
//   stop_btn       : request to stop (level)
//   bumper         : obstacle contact (level)
//   battery_low    : battery below threshold (level)
//   cmd_power_off  : driven in OFF and LOWBAT
//   cmd_on         : driven in ON
//   cmd_cleaning   : driven in CLEAN
//   cmd_evading    : driven in EVADE
//   seq_state      : current state (OFF=0 ON=1 CLEAN=2 EVADE=3 LOWBAT=4)
//   session_done   : one-cycle pulse when CLEAN ends by timeout
//   fault          : sticky stall fault
//
// Optional feature macro: STALL_DETECT_EN
//   Defined   : bumps per session are counted; once MAX_BUMPS is reached the
//               next evade completion goes to ON and sets fault. fault clears
//               on rst or when start_btn takes ON -> CLEAN.
//   Undefined : no bump counter, fault tied to 0, EVADE always returns to CLEAN.
//
// Event priority: rst > battery_low > stop_btn > bumper > start_btn > timer.
// An input only competes in states where it has an effect (e.g. bumper is
// meaningless in ON, so it cannot block start_btn there).
// -----------------------------------------------------------------------------
module aspiradora_mode_sequencer
  import aspiradora_seq_pkg::*;
#(
  parameter int CLEAN_CYCLES = DEF_CLEAN_CYCLES,
  parameter int EVADE_CYCLES = DEF_EVADE_CYCLES,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int MAX_BUMPS    = DEF_MAX_BUMPS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       bumper,
  input  logic       battery_low,
  output logic       cmd_power_off,
  output logic       cmd_on,
  output logic       cmd_cleaning,
  output logic       cmd_evading,
  output logic [2:0] seq_state,
  output logic       session_done,
  output logic       fault
);

  localparam logic [CNT_W-1:0] CLEAN_TC = CNT_W'(CLEAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVADE_TC = CNT_W'(EVADE_CYCLES - 1);

  seq_state_t       r_state;
  seq_state_t       w_state_next;
  logic [CMD_W-1:0] r_cmd;
  logic             r_session_done;
  logic             w_session_done_next;

  logic w_clean_tc;
  logic w_evade_tc;
  logic w_clean_load;
  logic w_evade_load;
  logic w_clean_en;
  logic w_evade_en;

`ifdef STALL_DETECT_EN
  localparam int BUMP_W = $clog2(MAX_BUMPS + 2);
  logic [BUMP_W-1:0] r_bump_cnt;
  logic              r_fault;
  logic              w_fault_set;
  logic              w_stall;

  assign w_stall = (r_bump_cnt >= BUMP_W'(MAX_BUMPS));
`else
  // Keeps the parameter referenced in builds without stall detection.
  localparam int UNUSED_MAX_BUMPS = MAX_BUMPS;
`endif

  // Clean timer restarts only on a fresh session (ON -> CLEAN) and is frozen
  // everywhere except CLEAN, so evade time never counts toward the session.
  assign w_clean_load = (r_state == S_ON)    && (w_state_next == S_CLEAN);
  assign w_clean_en   = (r_state == S_CLEAN);
  assign w_evade_load = (r_state == S_CLEAN) && (w_state_next == S_EVADE);
  assign w_evade_en   = (r_state == S_EVADE);

  seq_timer #(
    .CNT_W    (CNT_W),
    .TC_VALUE (CLEAN_TC)
  ) u_clean_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_clean_load),
    .i_en   (w_clean_en),
    .o_tc   (w_clean_tc)
  );

  seq_timer #(
    .CNT_W    (CNT_W),
    .TC_VALUE (EVADE_TC)
  ) u_evade_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_evade_load),
    .i_en   (w_evade_en),
    .o_tc   (w_evade_tc)
  );

  // Next-state logic
  always_comb begin
    w_state_next        = r_state;
    w_session_done_next = 1'b0;
`ifdef STALL_DETECT_EN
    w_fault_set         = 1'b0;
`endif
    case (r_state)
      S_OFF: begin
        if (start_btn && !battery_low) w_state_next = S_ON;
      end
      S_ON: begin
        if (battery_low)     w_state_next = S_LOWBAT;
        else if (stop_btn)   w_state_next = S_OFF;
        else if (start_btn)  w_state_next = S_CLEAN;
      end
      S_CLEAN: begin
        if (battery_low)     w_state_next = S_LOWBAT;
        else if (stop_btn)   w_state_next = S_ON;
        else if (bumper)     w_state_next = S_EVADE;
        else if (w_clean_tc) begin
          w_state_next        = S_ON;
          w_session_done_next = 1'b1;
        end
      end
      S_EVADE: begin
        // bumper is deliberately not looked at here: a held contact neither
        // extends nor restarts the manoeuvre.
        if (battery_low)     w_state_next = S_LOWBAT;
        else if (stop_btn)   w_state_next = S_ON;
        else if (w_evade_tc) begin
`ifdef STALL_DETECT_EN
          if (w_stall) begin
            w_state_next = S_ON;
            w_fault_set  = 1'b1;
          end else begin
            w_state_next = S_CLEAN;
          end
`else
          w_state_next = S_CLEAN;
`endif
        end
      end
      S_LOWBAT: begin
        if (!battery_low && stop_btn) w_state_next = S_OFF;
      end
      default: w_state_next = S_OFF;
    endcase
  end

  // State and registered outputs; commands decode the next state so they
  // switch on the same edge as seq_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_OFF;
      r_cmd          <= cmd_decode(S_OFF);
      r_session_done <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_cmd          <= cmd_decode(w_state_next);
      r_session_done <= w_session_done_next;
    end
  end

`ifdef STALL_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bump_cnt <= '0;
      r_fault    <= 1'b0;
    end else begin
      if (w_clean_load) begin
        r_bump_cnt <= '0;
      end else if (w_evade_load && !w_stall) begin
        r_bump_cnt <= r_bump_cnt + BUMP_W'(1);
      end
      // Starting a new session from ON is the only way to acknowledge a stall.
      if (w_clean_load) begin
        r_fault <= 1'b0;
      end else if (w_fault_set) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign fault = r_fault;
`else
  assign fault = 1'b0;
`endif

  assign cmd_power_off = r_cmd[CMD_POWER_OFF];
  assign cmd_on        = r_cmd[CMD_ON];
  assign cmd_cleaning  = r_cmd[CMD_CLEANING];
  assign cmd_evading   = r_cmd[CMD_EVADING];
  assign seq_state     = r_state;
  assign session_done  = r_session_done;

endmodule

// File: tb/tb_aspiradora_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aspiradora_mode_sequencer
// Directed scenarios with constant expectations, followed by a randomized run
// compared cycle by cycle against a behavioural model that tracks remaining
// clean/evade time as plain integers.
// -----------------------------------------------------------------------------
module tb_aspiradora_mode_sequencer;

  localparam int CLEAN_CYC = 10;
  localparam int EVADE_CYC = 3;
  localparam int MAXB      = 2;

  logic       clk = 1'b0;
  logic       rst, start_btn, stop_btn, bumper, battery_low;
  logic       cmd_power_off, cmd_on, cmd_cleaning, cmd_evading;
  logic [2:0] seq_state;
  logic       session_done, fault;
  logic [3:0] cmd_vec;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model
  int m_state      = 0;
  int m_clean_left = 0;
  int m_evade_left = 0;
  int m_bumps      = 0;
  bit m_done       = 1'b0;
  bit m_fault      = 1'b0;

  aspiradora_mode_sequencer #(
    .CLEAN_CYCLES (CLEAN_CYC),
    .EVADE_CYCLES (EVADE_CYC),
    .CNT_W        (8),
    .MAX_BUMPS    (MAXB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_btn     (start_btn),
    .stop_btn      (stop_btn),
    .bumper        (bumper),
    .battery_low   (battery_low),
    .cmd_power_off (cmd_power_off),
    .cmd_on        (cmd_on),
    .cmd_cleaning  (cmd_cleaning),
    .cmd_evading   (cmd_evading),
    .seq_state     (seq_state),
    .session_done  (session_done),
    .fault         (fault)
  );

  assign cmd_vec = {cmd_evading, cmd_cleaning, cmd_on, cmd_power_off};

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_cmd(input int st);
    case (st)
      1:       return 4'b0010;
      2:       return 4'b0100;
      3:       return 4'b1000;
      default: return 4'b0001;
    endcase
  endfunction

  // Drive one cycle of inputs, sample #1 after the edge, advance the model.
  task automatic step(input bit r, input bit s, input bit p, input bit b, input bit l);
    int nxt;
    rst = r; start_btn = s; stop_btn = p; bumper = b; battery_low = l;
    @(posedge clk);
    #1;
    nxt    = m_state;
    m_done = 1'b0;
    if (r) begin
      nxt = 0; m_bumps = 0; m_fault = 1'b0;
    end else begin
      case (m_state)
        0: if (s && !l) nxt = 1;
        1: begin
          if (l)      nxt = 4;
          else if (p) nxt = 0;
          else if (s) begin
            nxt = 2; m_clean_left = CLEAN_CYC; m_bumps = 0; m_fault = 1'b0;
          end
        end
        2: begin
          if (l)      nxt = 4;
          else if (p) nxt = 1;
          else if (b) begin
            nxt = 3; m_evade_left = EVADE_CYC; m_bumps++;
          end else if (m_clean_left <= 1) begin
            nxt = 1; m_done = 1'b1;
          end
          if (m_clean_left > 0) m_clean_left--;
        end
        3: begin
          if (l)      nxt = 4;
          else if (p) nxt = 1;
          else if (m_evade_left <= 1) begin
`ifdef STALL_DETECT_EN
            if (m_bumps >= MAXB) begin
              nxt = 1; m_fault = 1'b1;
            end else begin
              nxt = 2;
            end
`else
            nxt = 2;
`endif
          end else begin
            m_evade_left--;
          end
        end
        4: if (!l && p) nxt = 0;
        default: nxt = 0;
      endcase
    end
    m_state = nxt;
  endtask

  task automatic go_clean();
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    $display("reset: state=%0d cmd=%b done=%0b fault=%0b", seq_state, cmd_vec, session_done, fault);
    n_checks++; if (seq_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", seq_state); end
    n_checks++; if (cmd_vec !== 4'b0001) begin n_fail++; $display("FAIL reset_cmd: got %b want 0001", cmd_vec); end
    n_checks++; if (session_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", session_done); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
  endtask

  task automatic test_session_timeout();
    int done_at = 0, done_cnt = 0;
    logic [2:0] st_at_done = 3'd7;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    n_checks++; if (seq_state !== 3'd1) begin n_fail++; $display("FAIL timeout_on: got %0d want 1", seq_state); end
    step(0, 1, 0, 0, 0);
    n_checks++; if (cmd_vec !== 4'b0100) begin n_fail++; $display("FAIL timeout_clean_cmd: got %b want 0100", cmd_vec); end
    for (int i = 1; i <= 15; i++) begin
      step(0, 0, 0, 0, 0);
      if (session_done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) begin done_at = i; st_at_done = seq_state; end
      end
    end
    $display("timeout: done_at=%0d done_cnt=%0d state=%0d", done_at, done_cnt, st_at_done);
    n_checks++; if (done_at !== CLEAN_CYC) begin n_fail++; $display("FAIL timeout_len: got %0d want %0d", done_at, CLEAN_CYC); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL timeout_pulses: got %0d want 1", done_cnt); end
    n_checks++; if (st_at_done !== 3'd1) begin n_fail++; $display("FAIL timeout_state: got %0d want 1", st_at_done); end
  endtask

  task automatic test_evade_resume();
    int steps = 5, n_evade = 0, done_at = 0;
    logic [2:0] st_after = 3'd7;
    go_clean();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    if (cmd_evading === 1'b1) n_evade++;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0, 0, 0);
      steps++;
      if (cmd_evading === 1'b1) n_evade++;
      if (steps == 8) st_after = seq_state;
      if (session_done === 1'b1 && done_at == 0) done_at = steps;
    end
    $display("evade: evade_cycles=%0d resume_state=%0d done_at=%0d", n_evade, st_after, done_at);
    n_checks++; if (n_evade !== EVADE_CYC) begin n_fail++; $display("FAIL evade_len: got %0d want %0d", n_evade, EVADE_CYC); end
    n_checks++; if (st_after !== 3'd2) begin n_fail++; $display("FAIL evade_resume: got %0d want 2", st_after); end
    n_checks++; if (done_at !== 13) begin n_fail++; $display("FAIL evade_done_at: got %0d want 13", done_at); end
  endtask

  task automatic test_bumper_held();
    go_clean();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    $display("bumper_held: state after evade=%0d", seq_state);
    n_checks++; if (seq_state !== 3'd2) begin n_fail++; $display("FAIL held_no_extend: got %0d want 2", seq_state); end
    step(0, 0, 0, 1, 0);
    n_checks++; if (seq_state !== 3'd3) begin n_fail++; $display("FAIL held_retrigger: got %0d want 3", seq_state); end
  endtask

  task automatic test_lowbat();
    go_clean();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    $display("lowbat: state=%0d cmd=%b", seq_state, cmd_vec);
    n_checks++; if (seq_state !== 3'd4) begin n_fail++; $display("FAIL lowbat_enter: got %0d want 4", seq_state); end
    n_checks++; if (cmd_vec !== 4'b0001) begin n_fail++; $display("FAIL lowbat_cmd: got %b want 0001", cmd_vec); end
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    n_checks++; if (seq_state !== 3'd4) begin n_fail++; $display("FAIL lowbat_start_ignored: got %0d want 4", seq_state); end
    step(0, 0, 1, 0, 0);
    n_checks++; if (seq_state !== 3'd0) begin n_fail++; $display("FAIL lowbat_exit: got %0d want 0", seq_state); end
  endtask

  task automatic test_stop_bumper();
    go_clean();
    step(0, 0, 1, 1, 0);
    $display("stop_bumper: state=%0d done=%0b cmd=%b", seq_state, session_done, cmd_vec);
    n_checks++; if (seq_state !== 3'd1) begin n_fail++; $display("FAIL stopbump_state: got %0d want 1", seq_state); end
    n_checks++; if (session_done !== 1'b0) begin n_fail++; $display("FAIL stopbump_done: got %b want 0", session_done); end
    step(0, 0, 0, 0, 0);
    n_checks++; if (cmd_vec !== 4'b0010) begin n_fail++; $display("FAIL stopbump_no_evade: got %b want 0010", cmd_vec); end
  endtask

  task automatic test_reset_mid_evade();
    int done_at = 0;
    go_clean();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    n_checks++; if ({seq_state, cmd_vec} !== {3'd0, 4'b0001}) begin n_fail++; $display("FAIL rstevade: got state=%0d cmd=%b want 0/0001", seq_state, cmd_vec); end
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      step(0, 0, 0, 0, 0);
      if (session_done === 1'b1 && done_at == 0) done_at = i;
    end
    $display("reset_mid_evade: full session length=%0d", done_at);
    n_checks++; if (done_at !== CLEAN_CYC) begin n_fail++; $display("FAIL rstevade_full: got %0d want %0d", done_at, CLEAN_CYC); end
  endtask

  task automatic test_stall();
    go_clean();
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < EVADE_CYC; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < EVADE_CYC; i++) step(0, 0, 0, 0, 0);
    $display("stall: state=%0d fault=%0b", seq_state, fault);
`ifdef STALL_DETECT_EN
    n_checks++; if ({seq_state, fault} !== {3'd1, 1'b1}) begin n_fail++; $display("FAIL stall_set: got state=%0d fault=%b want 1/1", seq_state, fault); end
    step(0, 0, 0, 0, 0);
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL stall_sticky: got %b want 1", fault); end
    step(0, 1, 0, 0, 0);
    n_checks++; if ({seq_state, fault} !== {3'd2, 1'b0}) begin n_fail++; $display("FAIL stall_clear: got state=%0d fault=%b want 2/0", seq_state, fault); end
`else
    n_checks++; if ({seq_state, fault} !== {3'd2, 1'b0}) begin n_fail++; $display("FAIL nostall_resume: got state=%0d fault=%b want 2/0", seq_state, fault); end
`endif
  endtask

  task automatic test_random();
    logic [9:0] exp_v;
    bit r, s, p, b, l;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 149) == 0);
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 15) == 0);
      b = ($urandom_range(0, 7) == 0);
      l = ($urandom_range(0, 31) == 0);
      step(r, s, p, b, l);
      exp_v = {3'(m_state), exp_cmd(m_state), m_done, m_fault};
      $display("cyc %0d rst=%0b start=%0b stop=%0b bump=%0b bat=%0b -> state=%0d cmd=%b done=%0b fault=%0b",
               i, r, s, p, b, l, seq_state, cmd_vec, session_done, fault);
      n_checks++;
      if ({seq_state, cmd_vec, session_done, fault} !== exp_v) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got %b want %b", i, {seq_state, cmd_vec, session_done, fault}, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start_btn = 1'b0; stop_btn = 1'b0; bumper = 1'b0; battery_low = 1'b0;
    test_reset();
    test_session_timeout();
    test_evade_resume();
    test_bumper_held();
    test_lowbat();
    test_stop_bumper();
    test_reset_mid_evade();
    test_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
